uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, number of byte entries; SHALL be a power of two, 2..256.
REQ-002 Parameter AW, default 4, pointer width; SHALL equal log2(DEPTH).
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low; sampled on the rising edge of clk.
REQ-005 in__data  input  8  received byte from the UART receiver.
REQ-006 in__valid  input  1  in__data is valid this cycle.
REQ-007 out__ready  output  1  accept indication to the receiver; SHALL be constant 1.
REQ-008 out__data  output  8  head-of-queue byte.
REQ-009 out__valid  output  1  queue is non-empty and out__data is valid.
REQ-010 in__ready  input  1  downstream consumer accepts out__data this cycle.
REQ-011 out__count  output  AW+1  number of stored bytes, 0..DEPTH.
REQ-012 out__overflow  output  1  sticky flag: at least one byte was dropped.
REQ-013 in__clear  input  1  clears out__overflow.

Function
REQ-014 Push SHALL occur when in__valid=1 and the queue is not full, or when in__valid=1, full, and a pop occurs in the same cycle.
REQ-015 Pop SHALL occur when out__valid=1 and in__ready=1.
REQ-016 out__ready SHALL stay 1 so the receiver never stalls mid-frame; bytes arriving while full without a same-cycle pop SHALL be dropped.
REQ-017 A dropped byte SHALL set out__overflow on the next edge; queue contents, pointers and count SHALL be unchanged.
REQ-018 in__clear=1 SHALL clear out__overflow on the next edge; a drop in the same cycle takes priority and leaves it set.
REQ-019 Write latency SHALL be 1 cycle: a byte pushed into an empty queue appears on out__data with out__valid=1 on the following cycle; no combinational bypass.
REQ-020 out__data SHALL equal the entry at the read pointer whenever out__valid=1; its value is don't-care when empty.
REQ-021 out__data and out__valid SHALL be held stable while out__valid=1 and in__ready=0.
REQ-022 Write and read pointers are AW bits and SHALL wrap from DEPTH-1 to 0.
REQ-023 Count SHALL be +1 on push only, -1 on pop only, and unchanged on push+pop or on neither.
REQ-024 Full means count==DEPTH; empty means count==0; out__valid SHALL equal (count!=0).
REQ-025 Byte order SHALL be strictly FIFO; no byte is duplicated or reordered.

Reset
REQ-026 While rst=0 at an edge: pointers=0, count=0, out__valid=0, out__overflow=0; storage array is not reset.
REQ-027 Reset asserted mid-operation SHALL discard all stored bytes; in-flight push/pop in that cycle SHALL have no effect.
REQ-028 out__ready SHALL be 1 during and after reset.

Structure
REQ-029 DEPTH default, the 8-bit byte width and the overflow-flag semantics SHALL live in the shared uart package used by uartrx and its neighbours.
REQ-030 Storage SHALL be a separate sub-module fifo_mem (DEPTH x 8, one write port, one asynchronous read port); control logic stays in uart_rx_fifo.

Verification
REQ-031 Reset, then push 0x41, 0x42, 0x43 on consecutive cycles with in__ready=0 -> count=3, out__data=0x41, out__valid=1, held stable.
REQ-032 From REQ-031, in__ready=1 for 3 cycles -> out__data 0x41, 0x42, 0x43 in order, then out__valid=0, count=0.
REQ-033 Fill 16 bytes 0x00..0x0F, push 0xAA with in__ready=0 -> count=16, out__overflow=1, drained sequence 0x00..0x0F (0xAA absent).
REQ-034 Full queue, push 0x55 with in__ready=1 in the same cycle -> count stays 16, 0x55 emerges last after 0x01..0x0F.
REQ-035 40 bytes streamed with simultaneous push/pop every cycle across pointer wrap -> output matches input exactly, count stays 1, no overflow.
REQ-036 Overflow set, assert in__clear -> out__overflow=0 next cycle; repeat with a drop in the same cycle -> stays 1; assert rst=0 with 5 bytes stored -> out__valid=0 and count=0 next cycle.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART receive-path definitions: byte width, default queue depth and
// the sticky overflow-flag update rule used by the receiver and its neighbours.
package uart_rx_fifo_pkg;

  localparam int UART_BYTE_W     = 8;
  localparam int UART_FIFO_DEPTH = 16;
  localparam int UART_FIFO_AW    = 4;

  typedef logic [UART_BYTE_W-1:0] uart_byte_t;

  // A drop in the same cycle wins over a clear, so a lost byte is never hidden.
  function automatic logic ovf_next(input logic ovf, input logic drop, input logic clear);
    logic res;
    if (drop) begin
      res = 1'b1;
    end else if (clear) begin
      res = 1'b0;
    end else begin
      res = ovf;
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Byte storage for the UART receive queue: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module fifo_mem
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH = UART_FIFO_DEPTH,
  parameter int AW    = UART_FIFO_AW
) (
  input  logic            clk,
  input  logic            i_wr_en,
  input  logic [AW-1:0]   i_wr_addr,
  input  uart_byte_t      i_wr_data,
  input  logic [AW-1:0]   i_rd_addr,
  output uart_byte_t      o_rd_data
);

  uart_byte_t r_mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte queue between the UART receiver and its consumer. The receiver
// is never stalled; bytes arriving while full are dropped and flagged sticky.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH = UART_FIFO_DEPTH,
  parameter int AW    = UART_FIFO_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  uart_byte_t    in__data,
  input  logic          in__valid,
  output logic          out__ready,
  output uart_byte_t    out__data,
  output logic          out__valid,
  input  logic          in__ready,
  output logic [AW:0]   out__count,
  output logic          out__overflow,
  input  logic          in__clear
);

  localparam logic [AW:0] L_FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] L_ONE_COUNT  = (AW+1)'(1'b1);
  localparam logic [AW-1:0] L_ONE_PTR  = AW'(1'b1);

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_overflow;

  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_wr_en;
  logic [AW:0]   w_count_nxt;
  uart_byte_t    w_rd_data;

  assign w_full  = (r_count == L_FULL_COUNT);
  assign w_pop   = out__valid & in__ready;
  // A pop frees the slot this cycle, so a full queue can still accept a byte.
  assign w_push  = in__valid & (~w_full | w_pop);
  assign w_drop  = in__valid & w_full & ~w_pop;
  assign w_wr_en = w_push & rst;

  // Occupancy update: push and pop together leave the count unchanged
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + L_ONE_COUNT;
      2'b01:   w_count_nxt = r_count - L_ONE_COUNT;
      default: w_count_nxt = r_count;
    endcase
  end

  // Queue pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr     <= {AW{1'b0}};
      r_rptr     <= {AW{1'b0}};
      r_count    <= {(AW+1){1'b0}};
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + L_ONE_PTR;
      end else begin
        r_wptr <= r_wptr;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + L_ONE_PTR;
      end else begin
        r_rptr <= r_rptr;
      end
      r_count    <= w_count_nxt;
      r_overflow <= ovf_next(r_overflow, w_drop, in__clear);
    end
  end

  fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wptr),
    .i_wr_data (in__data),
    .i_rd_addr (r_rptr),
    .o_rd_data (w_rd_data)
  );

  assign out__ready    = 1'b1;
  assign out__data     = w_rd_data;
  assign out__valid    = (r_count != {(AW+1){1'b0}});
  assign out__count    = r_count;
  assign out__overflow = r_overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus a randomized run
// compared against a queue-based reference model.
module tb_uart_rx_fifo;
  import uart_rx_fifo_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [7:0]   in__data = 8'h00;
  logic         in__valid = 1'b0;
  logic         in__ready = 1'b0;
  logic         in__clear = 1'b0;
  logic         out__ready;
  logic [7:0]   out__data;
  logic         out__valid;
  logic [AW:0]  out__count;
  logic         out__overflow;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] mq[$];
  bit         m_ovf = 1'b0;

  uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .in__data      (in__data),
    .in__valid     (in__valid),
    .out__ready    (out__ready),
    .out__data     (out__data),
    .out__valid    (out__valid),
    .in__ready     (in__ready),
    .out__count    (out__count),
    .out__overflow (out__overflow),
    .in__clear     (in__clear)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Apply one cycle of inputs, advance the reference model, sample 1 time unit after the edge.
  task automatic step(input bit v, input logic [7:0] d, input bit rdy, input bit clr, input bit rs);
    bit pop;
    bit full;
    bit drop;
    in__valid = v;
    in__data  = d;
    in__ready = rdy;
    in__clear = clr;
    rst       = rs;
    @(posedge clk);
    if (!rs) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      pop  = (mq.size() != 0) && rdy;
      full = (mq.size() == DEPTH);
      drop = v && full && !pop;
      if (pop) void'(mq.pop_front());
      if (v && !drop) mq.push_back(d);
      if (drop) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    step(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h98, 1'b1, 1'b0, 1'b0);
    n_vec++; if (out__valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out__valid); end
    n_vec++; if (out__count !== 5'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", out__count); end
    n_vec++; if (out__overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", out__overflow); end
    n_vec++; if (out__ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", out__ready); end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    n_vec++; if (out__ready !== 1'b1 || out__valid !== 1'b0) begin
      n_err++; $display("FAIL post_reset: ready %b valid %b want 1 0", out__ready, out__valid);
    end
  endtask

  task automatic test_basic();
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 8'h41 + 8'(i), 1'b0, 1'b0, 1'b1);
    n_vec++; if (out__count !== 5'd3) begin n_err++; $display("FAIL basic_count: got %0d want 3", out__count); end
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (out__valid !== 1'b1 || out__data !== 8'h41) begin
        n_err++; $display("FAIL basic_hold: valid %b data %h want 1 41", out__valid, out__data);
      end
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    end
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (out__valid !== 1'b1 || out__data !== 8'h41 + 8'(i)) begin
        n_err++; $display("FAIL basic_order: valid %b data %h want 1 %h", out__valid, out__data, 8'h41 + 8'(i));
      end
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    end
    n_vec++; if (out__valid !== 1'b0 || out__count !== 5'd0) begin
      n_err++; $display("FAIL basic_empty: valid %b count %0d want 0 0", out__valid, out__count);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
    n_vec++; if (out__count !== 5'd16) begin n_err++; $display("FAIL ovf_count: got %0d want 16", out__count); end
    n_vec++; if (out__overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", out__overflow); end
    for (int i = 0; i < DEPTH; i++) begin
      n_vec++; if (out__valid !== 1'b1 || out__data !== 8'(i)) begin
        n_err++; $display("FAIL ovf_drain: valid %b data %h want 1 %h", out__valid, out__data, 8'(i));
      end
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    end
    n_vec++; if (out__valid !== 1'b0 || out__overflow !== 1'b1) begin
      n_err++; $display("FAIL ovf_after: valid %b ovf %b want 0 1", out__valid, out__overflow);
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp;
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h55, 1'b1, 1'b0, 1'b1);
    n_vec++; if (out__count !== 5'd16 || out__overflow !== 1'b0) begin
      n_err++; $display("FAIL fpp_count: count %0d ovf %b want 16 0", out__count, out__overflow);
    end
    for (int i = 0; i < DEPTH; i++) begin
      exp = (i < DEPTH - 1) ? 8'(i + 1) : 8'h55;
      n_vec++; if (out__valid !== 1'b1 || out__data !== exp) begin
        n_err++; $display("FAIL fpp_drain: valid %b data %h want 1 %h", out__valid, out__data, exp);
      end
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] sent[$];
    logic [7:0] d;
    do_reset();
    d = 8'($urandom);
    sent.push_back(d);
    step(1'b1, d, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      n_vec++; if (out__valid !== 1'b1 || out__data !== sent[0]) begin
        n_err++; $display("FAIL b2b_data: valid %b data %h want 1 %h", out__valid, out__data, sent[0]);
      end
      void'(sent.pop_front());
      d = 8'($urandom);
      sent.push_back(d);
      step(1'b1, d, 1'b1, 1'b0, 1'b1);
      n_vec++; if (out__count !== 5'd1) begin n_err++; $display("FAIL b2b_count: got %0d want 1", out__count); end
    end
    n_vec++; if (out__data !== sent[0] || out__overflow !== 1'b0) begin
      n_err++; $display("FAIL b2b_last: data %h ovf %b want %h 0", out__data, out__overflow, sent[0]);
    end
  endtask

  task automatic test_clear();
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
    n_vec++; if (out__overflow !== 1'b1) begin n_err++; $display("FAIL clr_set: got %b want 1", out__overflow); end
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    n_vec++; if (out__overflow !== 1'b0) begin n_err++; $display("FAIL clr_clear: got %b want 0", out__overflow); end
    step(1'b1, 8'hBB, 1'b0, 1'b1, 1'b1);
    n_vec++; if (out__overflow !== 1'b1) begin n_err++; $display("FAIL clr_drop_wins: got %b want 1", out__overflow); end
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, 1'b1);
    n_vec++; if (out__count !== 5'd5) begin n_err++; $display("FAIL clr_five: got %0d want 5", out__count); end
    step(1'b1, 8'hCC, 1'b1, 1'b0, 1'b0);
    n_vec++; if (out__valid !== 1'b0 || out__count !== 5'd0) begin
      n_err++; $display("FAIL mid_reset: valid %b count %0d want 0 0", out__valid, out__count);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    n_vec++; if (out__valid !== 1'b0 || out__ready !== 1'b1) begin
      n_err++; $display("FAIL mid_reset_after: valid %b ready %b want 0 1", out__valid, out__ready);
    end
  endtask

  task automatic test_random();
    bit v;
    bit rdy;
    bit clr;
    bit rs;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      rdy = (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      rs  = ($urandom_range(0, 99) != 0);
      step(v, 8'($urandom), rdy, clr, rs);
      n_vec++; if (out__count !== 5'(mq.size())) begin
        n_err++; $display("FAIL rand_count: got %0d want %0d", out__count, mq.size());
      end
      n_vec++; if (out__valid !== (mq.size() != 0)) begin
        n_err++; $display("FAIL rand_valid: got %b want %b", out__valid, mq.size() != 0);
      end
      n_vec++; if (out__overflow !== m_ovf) begin
        n_err++; $display("FAIL rand_ovf: got %b want %b", out__overflow, m_ovf);
      end
      if (mq.size() != 0) begin
        n_vec++; if (out__data !== mq[0]) begin
          n_err++; $display("FAIL rand_data: got %h want %h", out__data, mq[0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_clear();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
